// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if -- handshake/line bundle between a byte source and uart_tx.
//
// Signals:
//   i_tx_start  start request (source -> transmitter)
//   i_data      byte to send, N_DATA bits (source -> transmitter)
//   o_tx        serial line, idle high (transmitter -> line)
//   o_busy      frame in progress (transmitter -> source)
//   o_tx_done   one-cycle end-of-frame pulse (transmitter -> source)
//
// Modports:
//   master  the byte source (drives start/data, observes status)
//   slave   the transmitter itself
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int N_DATA = 8
);
    logic              i_tx_start;
    logic [N_DATA-1:0] i_data;
    logic              o_tx;
    logic              o_busy;
    logic              o_tx_done;

    modport master (
        output i_tx_start,
        output i_data,
        input  o_tx,
        input  o_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_tx_start,
        input  i_data,
        output o_tx,
        output o_busy,
        output o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1-style UART transmitter, LSB first, 16x-oversampled ticks.
//
// Sits downstream of the BIP result path. One byte is accepted per start
// strobe while idle and serialized on o_tx; a one-cycle o_tx_done pulse marks
// the first idle cycle after the stop bit. The tick divider is internal.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous, active-high reset (priority over everything)
//   tx_if    uart_tx_if.slave: i_tx_start, i_data in; o_tx, o_busy,
//            o_tx_done out (all outputs registered)
//
// Parameters:
//   N_DATA         data bits per frame
//   N_STOP_TICKS   stop length in ticks (16 = 1 stop bit, 32 = 2)
//   CLK_PER_TICK   clock cycles per oversampling tick, >= 1
//   TICKS_PER_BIT  ticks per start/data bit
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int N_DATA        = 8,
    parameter int N_STOP_TICKS  = 16,
    parameter int CLK_PER_TICK  = 326,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic     i_clk,
    input  logic     i_reset,
    uart_tx_if.slave tx_if
);

    localparam int DIV_W  = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int TMAX   = (TICKS_PER_BIT > N_STOP_TICKS) ? TICKS_PER_BIT : N_STOP_TICKS;
    localparam int TCNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BCNT_W = (N_DATA > 1) ? $clog2(N_DATA) : 1;

    localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(0);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_PER_TICK - 1);
    localparam logic [TCNT_W-1:0] TCNT_ZERO = TCNT_W'(0);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] BIT_LAST  = TCNT_W'(TICKS_PER_BIT - 1);
    localparam logic [TCNT_W-1:0] STOP_LAST = TCNT_W'(N_STOP_TICKS - 1);
    localparam logic [BCNT_W-1:0] BCNT_ZERO = BCNT_W'(0);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(N_DATA - 1);
    localparam logic [N_DATA-1:0] SH_ZERO   = N_DATA'(0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state_r;
    logic [DIV_W-1:0]  div_r;
    logic [TCNT_W-1:0] tcnt_r;
    logic [BCNT_W-1:0] bcnt_r;
    logic [N_DATA-1:0] shreg_r;
    logic [N_DATA-1:0] shreg_nx_s;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;
    logic              tick_s;

    // Tick strobe on the divider's terminal count; with CLK_PER_TICK = 1 the
    // divider is permanently zero and this fires every cycle.
    assign tick_s     = (div_r == DIV_LAST);
    assign shreg_nx_s = shreg_r >> 1'b1;

    // Tick divider: parked at zero in IDLE so each start bit has exact width.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_r <= DIV_ZERO;
        end else if ((state_r == ST_IDLE) || tick_s) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // Frame sequencer: the line value is registered one cycle ahead of each
    // state change so o_tx switches exactly when the new bit period begins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            tcnt_r  <= TCNT_ZERO;
            bcnt_r  <= BCNT_ZERO;
            shreg_r <= SH_ZERO;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx_if.i_tx_start) begin
                        shreg_r <= tx_if.i_data;
                        tcnt_r  <= TCNT_ZERO;
                        bcnt_r  <= BCNT_ZERO;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (tcnt_r == BIT_LAST) begin
                            tcnt_r  <= TCNT_ZERO;
                            bcnt_r  <= BCNT_ZERO;
                            tx_r    <= shreg_r[0];
                            state_r <= ST_DATA;
                        end else begin
                            tcnt_r <= tcnt_r + TCNT_ONE;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (tcnt_r == BIT_LAST) begin
                            tcnt_r  <= TCNT_ZERO;
                            shreg_r <= shreg_nx_s;
                            bcnt_r  <= bcnt_r + BCNT_ONE;
                            if (bcnt_r == DATA_LAST) begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end else begin
                                tx_r <= shreg_nx_s[0];
                            end
                        end else begin
                            tcnt_r <= tcnt_r + TCNT_ONE;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (tcnt_r == STOP_LAST) begin
                            tcnt_r  <= TCNT_ZERO;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            tcnt_r <= tcnt_r + TCNT_ONE;
                        end
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_if.o_tx      = tx_r;
    assign tx_if.o_busy    = busy_r;
    assign tx_if.o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- scoreboard bench for uart_tx.
//
// Two instances share one clock:
//   dut_a: CLK_PER_TICK = 2, one stop bit  (frame = 320 cycles)
//   dut_b: CLK_PER_TICK = 1, two stop bits (frame = 176 cycles)
// The stimulus side decides, from its own notion of when each transmitter is
// free, which start strobes are accepted and queues the expected frame
// (byte + first start-bit cycle). The monitor pops a frame when its start
// cycle arrives and compares {o_tx, o_busy, o_tx_done} every cycle against
// the waveform derived from bit-period arithmetic.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int ND     = 8;
    localparam int TPB    = 16;
    localparam int CPT_A  = 2;
    localparam int STOP_A = 16;
    localparam int CPT_B  = 1;
    localparam int STOP_B = 32;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    int     free_c[2];
    int     abort_c[2];
    frame_t q0[$];
    frame_t q1[$];
    frame_t cur[2];
    bit     have[2];
    bit     acc;

    uart_tx_if #(.N_DATA(ND)) ifa ();
    uart_tx_if #(.N_DATA(ND)) ifb ();

    uart_tx #(.N_DATA(ND), .N_STOP_TICKS(STOP_A), .CLK_PER_TICK(CPT_A), .TICKS_PER_BIT(TPB))
        dut_a (.i_clk(clk), .i_reset(rst_a), .tx_if(ifa));

    uart_tx #(.N_DATA(ND), .N_STOP_TICKS(STOP_B), .CLK_PER_TICK(CPT_B), .TICKS_PER_BIT(TPB))
        dut_b (.i_clk(clk), .i_reset(rst_b), .tx_if(ifb));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bit_len(input int id);
        return TPB * ((id == 0) ? CPT_A : CPT_B);
    endfunction

    function automatic int frame_len(input int id);
        return ((1 + ND) * TPB + ((id == 0) ? STOP_A : STOP_B)) * ((id == 0) ? CPT_A : CPT_B);
    endfunction

    // Expected {tx, busy, done} at cycle k for frame f (off == frame_len is the done cycle).
    function automatic logic [2:0] expect_line(input int id, input frame_t f, input int k);
        int off;
        int bl;
        off = k - f.start;
        bl  = bit_len(id);
        if (off < bl)              return 3'b010;
        if (off < (1 + ND) * bl)   return {f.data[(off - bl) / bl], 2'b10};
        if (off < frame_len(id))   return 3'b110;
        return 3'b101;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One cycle of stimulus plus the bench's own acceptance decision.
    task automatic step(input int id, input logic st, input logic [7:0] d,
                        input logic rs, output bit accepted);
        frame_t f;
        @(negedge clk);
        accepted = 1'b0;
        if (id == 0) begin
            ifa.i_tx_start = st; ifa.i_data = d; rst_a = rs;
        end else begin
            ifb.i_tx_start = st; ifb.i_data = d; rst_b = rs;
        end
        if (rs) begin
            if (cyc < free_c[id]) abort_c[id] = cyc + 1;
            free_c[id] = cyc + 1;
        end else if (st && (cyc >= free_c[id])) begin
            f.data  = d;
            f.start = cyc + 1;
            if (id == 0) q0.push_back(f); else q1.push_back(f);
            free_c[id] = cyc + 1 + frame_len(id);
            accepted   = 1'b1;
        end
    endtask

    task automatic idle(input int id, input int n);
        bit a;
        repeat (n) step(id, 1'b0, 8'($urandom), 1'b0, a);
    endtask

    task automatic send(input int id, input logic [7:0] d);
        bit a;
        step(id, 1'b1, d, 1'b0, a);
    endtask

    // Run until the transmitter is free; optionally fire stray start strobes.
    task automatic wait_free(input int id, input bit junk);
        bit a;
        while (cyc < free_c[id])
            step(id, junk && ($urandom_range(0, 15) == 0), 8'($urandom), 1'b0, a);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [2:0] mon_act;
        logic [2:0] mon_exp;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int id = 0; id < 2; id++) begin
                    if (!have[id]) begin
                        if (id == 0 && q0.size() > 0 && q0[0].start == cyc) begin
                            cur[id] = q0.pop_front(); have[id] = 1'b1;
                        end else if (id == 1 && q1.size() > 0 && q1[0].start == cyc) begin
                            cur[id] = q1.pop_front(); have[id] = 1'b1;
                        end
                    end
                    if (have[id] && cur[id].start < abort_c[id] && cyc >= abort_c[id])
                        have[id] = 1'b0;
                    mon_exp = 3'b100;
                    if (have[id]) begin
                        mon_exp = expect_line(id, cur[id], cyc);
                        if (cyc - cur[id].start >= frame_len(id)) have[id] = 1'b0;
                    end
                    mon_act = (id == 0) ? {ifa.o_tx, ifa.o_busy, ifa.o_tx_done}
                                        : {ifb.o_tx, ifb.o_busy, ifb.o_tx_done};
                    checks++;
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL line_%s cycle %0d: tx/busy/done got %b expected %b",
                                 (id == 0) ? "a" : "b", cyc, mon_act, mon_exp);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog cycle=%0d limit=60000", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Stimulus
    initial begin
        int t0;
        free_c[0] = 0; free_c[1] = 0; abort_c[0] = 0; abort_c[1] = 0;
        have[0] = 1'b0; have[1] = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.i_tx_start = 1'b1; ifa.i_data = 8'h5A;
        ifb.i_tx_start = 1'b1; ifb.i_data = 8'h5A;

        // Reset with start held: nothing must be sent.
        step(0, 1'b1, 8'h5A, 1'b1, acc);
        step(0, 1'b1, 8'h5A, 1'b1, acc);
        idle(0, 5);

        // Single 0xA5 frame with a rejected 0xFF strobe at T+100.
        send(0, 8'hA5);
        t0 = cyc;
        while (cyc < t0 + 99) step(0, 1'b0, 8'h00, 1'b0, acc);
        step(0, 1'b1, 8'hFF, 1'b0, acc);
        check("busy_reject_accepted", int'(acc), 0);
        wait_free(0, 1'b0);
        idle(0, 10);

        // Back-to-back with start held high: 0x00 then 0xFF.
        acc = 1'b0;
        while (!acc) step(0, 1'b1, 8'h00, 1'b0, acc);
        t0 = cyc;
        acc = 1'b0;
        while (!acc) step(0, 1'b1, 8'hFF, 1'b0, acc);
        check("b2b_second_accept_cycle", cyc, t0 + 1 + frame_len(0));
        wait_free(0, 1'b0);
        idle(0, 10);

        // Reset mid-frame at T+150, then a clean 0x3C frame.
        send(0, 8'h96);
        t0 = cyc;
        while (cyc < t0 + 149) step(0, 1'b0, 8'h00, 1'b0, acc);
        step(0, 1'b0, 8'h00, 1'b1, acc);
        idle(0, 3);
        send(0, 8'h3C);
        wait_free(0, 1'b0);
        idle(0, 10);

        // Randomized frames with stray strobes while busy.
        repeat (12) begin
            idle(0, $urandom_range(0, 12));
            send(0, 8'($urandom));
            wait_free(0, 1'b1);
        end
        idle(0, 10);

        // Second instance: two stop bits, one tick per clock.
        step(1, 1'b0, 8'h00, 1'b0, acc);
        idle(1, 3);
        send(1, 8'h81);
        wait_free(1, 1'b0);
        idle(1, 5);
        repeat (4) begin
            idle(1, $urandom_range(0, 8));
            send(1, 8'($urandom));
            wait_free(1, 1'b1);
        end
        idle(1, 10);

        check("queue_a_drained", q0.size() + int'(have[0]), 0);
        check("queue_b_drained", q1.size() + int'(have[1]), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter downstream of the BIP result path.
- Accepts one byte per start strobe and serializes it on o_tx: 8N1, LSB first, 16x-oversampled tick timing.
- Raises a one-cycle o_tx_done pulse when the stop bit completes; the system top uses this pulse to end a run.
- Contains its own tick divider, so no external baud generator is needed.

Parameters:
- N_DATA, 8, data bits per frame.
- N_STOP_TICKS, 16, stop-bit length in ticks (16 = 1 stop bit, 32 = 2 stop bits).
- CLK_PER_TICK, 326, clock cycles per oversampling tick (50 MHz / (9600 x 16)); must be >= 1.
- TICKS_PER_BIT, 16, ticks per start/data bit.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_tx_start  in  1  start request; sampled only in IDLE.
- i_data  in  N_DATA  byte to send; captured in the cycle i_tx_start is accepted.
- o_tx  out  1  serial line; idle high.
- o_busy  out  1  high from the cycle after acceptance until the return to IDLE.
- o_tx_done  out  1  one-cycle pulse at frame end.

Behaviour:
- One clock domain. Reset is synchronous and active-high and takes priority over all other inputs. On reset:
  - state = IDLE
  - o_tx = 1, o_busy = 0, o_tx_done = 0
  - tick divider, tick counter, bit counter and shift register = 0
- States: IDLE, START, DATA, STOP.
- Tick generator:
  - Divider counts 0..CLK_PER_TICK-1 and emits tick on the terminal count.
  - Held at 0 in IDLE, so every frame's start bit has exact width.
- IDLE:
  - o_tx = 1.
  - If i_tx_start = 1: latch i_data into the shift register, clear the counters, go to START.
  - Acceptance cycle = cycle T.
- START:
  - o_tx = 0 from cycle T+1.
  - After TICKS_PER_BIT ticks, go to DATA with bit counter = 0.
- DATA:
  - o_tx = shift register bit 0.
  - Every TICKS_PER_BIT ticks, shift right by one and increment the bit counter.
  - After bit N_DATA-1 completes, go to STOP.
- STOP:
  - o_tx = 1 for N_STOP_TICKS ticks, then go to IDLE.
  - o_tx_done is asserted for exactly the first IDLE cycle.
- o_tx is registered, so there are no glitches.
- Frame length from T+1 to the return to IDLE: ((1+N_DATA) x TICKS_PER_BIT + N_STOP_TICKS) x CLK_PER_TICK cycles.
- i_tx_start while busy (START/DATA/STOP) is ignored; it is neither queued nor able to corrupt the frame. i_data changes after acceptance have no effect.
- i_tx_start held high continuously: a new frame is accepted in the same cycle o_tx_done pulses (back-to-back frames with no idle gap). A pulse still high in that cycle therefore starts a second frame; single-frame users must drop the start strobe within the frame.
- Reset mid-frame: the next cycle returns to IDLE with o_tx = 1 and no o_tx_done pulse. The partial frame is abandoned.
- CLK_PER_TICK = 1: a tick occurs every cycle; the timing formulas above still hold.

Test Plan:
- Reset: hold i_reset for 2 cycles with i_tx_start = 1 -> o_tx = 1, o_busy = 0, o_tx_done = 0 throughout; nothing is sent.
- Single frame with CLK_PER_TICK = 2, i_data = 0xA5, one-cycle start at T:
  - o_tx low on T+1..T+32.
  - Then 32-cycle bit periods with values 1,0,1,0,0,1,0,1.
  - Then high for 32 cycles.
  - o_tx_done pulses exactly once, at T+321.
  - o_busy is high on T+1..T+320.
- Busy rejection: during the 0xA5 frame, pulse i_tx_start with i_data = 0xFF at T+100 -> the line pattern is unchanged, one done pulse, then idle.
- Back-to-back: i_tx_start held high, data 0x00 then 0xFF -> the second start bit begins at the cycle after the first done pulse; no idle-high gap beyond the stop bit.
- Reset mid-frame: assert i_reset at T+150 for 1 cycle -> o_tx = 1 next cycle, o_tx_done never pulses, and a later start of 0x3C transmits a clean frame.
- Two stop bits: N_STOP_TICKS = 32, CLK_PER_TICK = 1, data 0x81 -> high stop period of 32 cycles, done at T+177.
